flag_branch_resolver: RTL and testbench

FLAG_BRANCH_RESOLVER -- requirements
Module: flag_branch_resolver

---
 rtl/flag_branch_resolver_pkg.sv | 36 +++
 rtl/cond_decode.sv | 39 +++
 rtl/flag_branch_resolver.sv | 101 ++++++++++
 tb/tb_flag_branch_resolver.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/flag_branch_resolver_pkg.sv
// Shared types for the flag branch resolver: condition codes, FSM states and
// flag bit positions within the ZCSO register.
package flag_branch_resolver_pkg;

    typedef enum logic [3:0] {
        COND_AL = 4'h0,
        COND_Z  = 4'h1,
        COND_NZ = 4'h2,
        COND_C  = 4'h3,
        COND_NC = 4'h4,
        COND_S  = 4'h5,
        COND_NS = 4'h6,
        COND_O  = 4'h7,
        COND_NO = 4'h8,
        COND_LT = 4'h9,
        COND_GE = 4'hA,
        COND_LE = 4'hB,
        COND_GT = 4'hC,
        COND_BE = 4'hD,
        COND_A  = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        StIdle,
        StSample,
        StEval,
        StFlush
    } state_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_O = 3;

endpackage

// File: rtl/cond_decode.sv
// Combinational condition-code decode against a captured ZCSO flag set.
module cond_decode
    import flag_branch_resolver_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic z, c, s, o;

    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign s = flags[FLAG_S];
    assign o = flags[FLAG_O];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_Z:  taken = z;
            COND_NZ: taken = !z;
            COND_C:  taken = c;
            COND_NC: taken = !c;
            COND_S:  taken = s;
            COND_NS: taken = !s;
            COND_O:  taken = o;
            COND_NO: taken = !o;
            COND_LT: taken = s != o;
            COND_GE: taken = s == o;
            COND_LE: taken = z || (s != o);
            COND_GT: taken = !z && (s == o);
            COND_BE: taken = c || z;
            COND_A:  taken = !c && !z;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_resolver.sv
// Resolves one conditional branch at a time: latch request, wait for stable
// flags, decode, then redirect the PC and hold flush on a taken branch.
module flag_branch_resolver
    import flag_branch_resolver_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        cond,
    input  logic [ADDR_W-1:0] target,
    input  logic [3:0]        ZCSO,
    input  logic              flags_busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              resolved_valid,
    output logic              resolved_taken,
    output logic [15:0]       taken_count
);

    // The EVAL cycle is the first flush cycle, so the counter covers the remainder.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_e              state_q;
    logic [3:0]          cond_q;
    logic [ADDR_W-1:0]   target_q;
    logic [3:0]          flags_q;
    logic [3:0]          flush_cnt_q;
    logic [15:0]         taken_count_q;
    logic                dec_taken;

    cond_decode u_cond_decode (
        .cond  (cond_q),
        .flags (flags_q),
        .taken (dec_taken)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cond_q        <= 4'd0;
            target_q      <= '0;
            flags_q       <= 4'd0;
            flush_cnt_q   <= 4'd0;
            taken_count_q <= 16'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        cond_q   <= cond;
                        target_q <= target;
                        state_q  <= StSample;
                    end
                end
                StSample: begin
                    if (!flags_busy) begin
                        flags_q <= ZCSO;
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    if (dec_taken) begin
                        if (taken_count_q != 16'hFFFF) begin
                            taken_count_q <= taken_count_q + 16'd1;
                        end
                        if (FLUSH_CYCLES > 1) begin
                            flush_cnt_q <= FLUSH_LOAD;
                            state_q     <= StFlush;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign req_ready      = (state_q == StIdle);
    assign resolved_valid = (state_q == StEval);
    assign resolved_taken = (state_q == StEval) && dec_taken;
    assign pc_load        = (state_q == StEval) && dec_taken;
    assign flush          = ((state_q == StEval) && dec_taken) || (state_q == StFlush);
    assign pc_target      = target_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_flag_branch_resolver.sv
// Randomized self-checking bench for flag_branch_resolver against a
// behavioural condition/timing model.
module tb_flag_branch_resolver;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned FC     = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        cond = 4'd0;
    logic [ADDR_W-1:0] target = '0;
    logic [3:0]        ZCSO = 4'd0;
    logic              flags_busy = 1'b0;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              flush;
    logic              resolved_valid;
    logic              resolved_taken;
    logic [15:0]       taken_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    flag_branch_resolver #(
        .ADDR_W       (ADDR_W),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .cond           (cond),
        .target         (target),
        .ZCSO           (ZCSO),
        .flags_busy     (flags_busy),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .flush          (flush),
        .resolved_valid (resolved_valid),
        .resolved_taken (resolved_taken),
        .taken_count    (taken_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Odd codes in each pair test the predicate, the following even code its inverse.
    function automatic bit ref_taken(input int c, input logic [3:0] f);
        bit lt, le, be, base;
        lt = f[2] ^ f[3];
        le = f[0] | lt;
        be = f[1] | f[0];
        if (c == 0) return 1'b1;
        if (c == 15) return 1'b0;
        if (c <= 8) begin
            base = f[(c - 1) / 2];
        end else begin
            case ((c - 9) / 2)
                0:       base = lt;
                1:       base = le;
                default: base = be;
            endcase
        end
        return base ^ (c % 2 == 0);
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_branch(input logic [3:0] c, input logic [3:0] f_busy, input logic [3:0] f,
                              input logic [15:0] tgt, input int busy, input bit noise);
        bit exp_taken;
        int eval_cyc, ready_cyc;
        exp_taken = ref_taken(int'(c), f);
        eval_cyc  = 2 + busy;
        ready_cyc = exp_taken ? eval_cyc + int'(FC) : eval_cyc + 1;
        check("ready_at_request", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        cond       = c;
        target     = tgt;
        ZCSO       = (busy > 0) ? f_busy : f;
        flags_busy = (busy > 0);
        @(posedge clock);
        #1;
        if (noise) begin
            cond   = 4'($urandom);
            target = 16'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        for (int k = 1; k <= ready_cyc; k++) begin
            if (k <= busy) begin
                flags_busy = 1'b1;
                ZCSO       = f_busy;
            end else if (k == busy + 1) begin
                flags_busy = 1'b0;
                ZCSO       = f;
            end else begin
                flags_busy = 1'($urandom);
                ZCSO       = 4'($urandom);
            end
            @(negedge clock);
            check("resolved_valid", {31'd0, resolved_valid}, {31'd0, k == eval_cyc});
            if (k == eval_cyc) begin
                check("resolved_taken", {31'd0, resolved_taken}, {31'd0, exp_taken});
                check("pc_load", {31'd0, pc_load}, {31'd0, exp_taken});
                if (exp_taken) begin
                    check("pc_target", {16'd0, pc_target}, {16'd0, tgt});
                    if (exp_count < 65535) exp_count++;
                end
            end else begin
                check("pc_load_idle", {31'd0, pc_load}, 32'd0);
            end
            if (k >= eval_cyc) begin
                check("flush", {31'd0, flush},
                      {31'd0, exp_taken && (k < eval_cyc + int'(FC))});
            end
            check("req_ready", {31'd0, req_ready}, {31'd0, k == ready_cyc});
            if (k == ready_cyc) begin
                req_valid = 1'b0;
                check("taken_count", {16'd0, taken_count}, exp_count);
            end else begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_pc_load", {31'd0, pc_load}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_resolved_valid", {31'd0, resolved_valid}, 32'd0);
        check("rst_resolved_taken", {31'd0, resolved_taken}, 32'd0);
        check("rst_pc_target", {16'd0, pc_target}, 32'd0);
        check("rst_taken_count", {16'd0, taken_count}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed cases
        run_branch(4'b0001, 4'b0000, 4'b0001, 16'h1234, 0, 1'b0);
        run_branch(4'b1001, 4'b0000, 4'b1000, 16'h2222, 0, 1'b0);
        run_branch(4'b1001, 4'b0000, 4'b1100, 16'h3333, 0, 1'b0);
        run_branch(4'b0001, 4'b0000, 4'b0001, 16'h4444, 3, 1'b0);
        run_branch(4'b1111, 4'b0000, 4'b1111, 16'h5555, 0, 1'b1);

        // Exhaustive code x flag sweep with random stalls and ignored requests
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                run_branch(4'(c), 4'($urandom), 4'(f), 16'($urandom),
                           int'($urandom_range(0, 2)), 1'($urandom));
            end
        end
        for (int n = 0; n < 100; n++) begin
            run_branch(4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
                       int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Reset while flushing a taken branch
        req_valid = 1'b1;
        cond      = 4'b0000;
        target    = 16'hBEEF;
        ZCSO      = 4'd0;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        check("flush_before_reset", {31'd0, flush}, 32'd1);
        reset = 1'b0;
        #1;
        exp_count = 0;
        check("flush_in_reset", {31'd0, flush}, 32'd0);
        check("pc_load_in_reset", {31'd0, pc_load}, 32'd0);
        check("count_in_reset", {16'd0, taken_count}, exp_count);
        check("ready_in_reset", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        run_branch(4'b0010, 4'b0000, 4'b0000, 16'h0ABC, 0, 1'b0);

        // Preset stands in for 65533 earlier taken branches
        @(negedge clock);
        force dut.taken_count_q = 16'hFFFD;
        #1;
        release dut.taken_count_q;
        exp_count = 65533;
        for (int n = 0; n < 4; n++) begin
            run_branch(4'b0000, 4'b0000, 4'($urandom), 16'($urandom), 0, 1'b0);
        end
        check("count_saturated", {16'd0, taken_count}, 32'hFFFF);
        run_branch(4'b1111, 4'b0000, 4'b0000, 16'h7777, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
